// File: rtl/axis_app_sink_checker.sv
// ---------------------------------------------------------------------------
// axis_app_sink_checker
//
// Application stand-in that consumes the generator's app-side TX stream.
// It drives a programmable tready pattern as backpressure, checks AXI-Stream
// handshake stability and tkeep legality, and accumulates beat, byte, packet
// and stall statistics for the stats/debug bus. Single clock: traffic_clk.
//
// Optional feature macro: SINK_PKT_LEN_STATS_EN
//   defined   -> per-packet byte length tracking drives min_pkt_len/max_pkt_len
//   undefined -> min_pkt_len/max_pkt_len are tied to 0, no accumulator exists
//
// Parameters
//   DWIDTH   tdata width in bits (multiple of 8, 64..512)
//   CNT_SAT  1 = counters saturate at all-ones, 0 = counters wrap
//
// Ports
//   traffic_clk   clock
//   rstn          asynchronous active-low reset
//   s_tdata/s_tkeep/s_tlast/s_tvalid/s_tready   AXI-Stream slave
//   ready_mode    0 always, 1 periodic, 2 LFSR random, 3 never
//   ready_duty    ready threshold for modes 1 and 2
//   lfsr_seed     LFSR seed (0 maps to 16'hACE1)
//   clear         synchronous clear of counters, errors, LFSR and phase
//   beat_cnt/byte_cnt/pkt_cnt/stall_cnt   statistics
//   proto_err     sticky error flag
//   err_code      code of the first error seen (0 = none)
//   min_pkt_len/max_pkt_len               packet length statistics
// ---------------------------------------------------------------------------
module axis_app_sink_checker #(
    parameter int DWIDTH  = 512,
    parameter int CNT_SAT = 1
) (
    input  logic                  traffic_clk,
    input  logic                  rstn,
    input  logic [DWIDTH-1:0]     s_tdata,
    input  logic [DWIDTH/8-1:0]   s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [1:0]            ready_mode,
    input  logic [7:0]            ready_duty,
    input  logic [15:0]           lfsr_seed,
    input  logic                  clear,
    output logic [31:0]           beat_cnt,
    output logic [63:0]           byte_cnt,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           stall_cnt,
    output logic                  proto_err,
    output logic [2:0]            err_code,
    output logic [31:0]           min_pkt_len,
    output logic [31:0]           max_pkt_len
);

    localparam int KW  = DWIDTH / 8;
    localparam int PCW = $clog2(KW + 1);

    // -----------------------------------------------------------------------
    // Popcount of tkeep as a running prefix-sum chain
    // -----------------------------------------------------------------------
    logic [PCW-1:0] pc_chain [0:KW];
    logic [PCW-1:0] keep_pc;

    assign pc_chain[0] = '0;
    generate
        for (genvar gi = 0; gi < KW; gi++) begin : g_popcount
            assign pc_chain[gi+1] = pc_chain[gi] + {{(PCW-1){1'b0}}, s_tkeep[gi]};
        end
    endgenerate
    assign keep_pc = pc_chain[KW];

    // -----------------------------------------------------------------------
    // Backpressure generation
    // -----------------------------------------------------------------------
    logic        ready_reg, ready_next;
    logic [7:0]  phase_reg, phase_next;
    logic [15:0] lfsr_reg, lfsr_next;
    logic [15:0] seed_mapped;
    logic        lfsr_fb;

    // The reset value of the LFSR comes from lfsr_seed, so the seed must be
    // stable while rstn is low.
    assign seed_mapped = (lfsr_seed == 16'h0000) ? 16'hACE1 : lfsr_seed;
    // Fibonacci taps 16,14,13,11 (bit indices 15,13,12,10), shifting left.
    assign lfsr_fb     = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_comb begin
        ready_next = 1'b0;
        case (ready_mode)
            2'd0:    ready_next = 1'b1;
            2'd1:    ready_next = (phase_reg < ready_duty);
            2'd2:    ready_next = (lfsr_reg[7:0] < ready_duty);
            default: ready_next = 1'b0;
        endcase
        // clear restarts the pattern sources but never the ready flop itself
        phase_next = clear ? 8'd0       : phase_reg + 8'd1;
        lfsr_next  = clear ? seed_mapped : {lfsr_reg[14:0], lfsr_fb};
    end

    always_ff @(posedge traffic_clk or negedge rstn) begin
        if (!rstn) begin
            ready_reg <= 1'b0;
            phase_reg <= 8'd0;
            lfsr_reg  <= seed_mapped;
        end else begin
            ready_reg <= ready_next;
            phase_reg <= phase_next;
            lfsr_reg  <= lfsr_next;
        end
    end

    assign s_tready = ready_reg;

    // -----------------------------------------------------------------------
    // Handshake and protocol checking
    // -----------------------------------------------------------------------
    logic              accept;
    logic              stall;
    logic              pend_reg;
    logic [DWIDTH-1:0] pend_data_reg;
    logic [KW-1:0]     pend_keep_reg;
    logic              pend_last_reg;
    logic [KW-1:0]     keep_inc;
    logic              keep_contig;
    logic              err1, err2, err3, err4;
    logic [2:0]        err_cur;

    assign accept   = s_tvalid & ready_reg;
    assign stall    = s_tvalid & ~ready_reg;
    assign keep_inc = s_tkeep + KW'(1);
    // 2^k-1 patterns have no set bit in common with their increment
    assign keep_contig = (s_tkeep != '0) && ((s_tkeep & keep_inc) == '0);

    assign err1 = pend_reg & ~s_tvalid;
    assign err2 = pend_reg & s_tvalid &
                  ((s_tdata != pend_data_reg) || (s_tkeep != pend_keep_reg) ||
                   (s_tlast != pend_last_reg));
    assign err3 = accept & ~s_tlast & (s_tkeep != {KW{1'b1}});
    assign err4 = accept & s_tlast & ~keep_contig;

    always_comb begin
        err_cur = 3'd0;
        if      (err1) err_cur = 3'd1;
        else if (err2) err_cur = 3'd2;
        else if (err3) err_cur = 3'd3;
        else if (err4) err_cur = 3'd4;
    end

    // Snapshot of the stalled beat; datapath only, no reset needed.
    always_ff @(posedge traffic_clk) begin
        if (stall) begin
            pend_data_reg <= s_tdata;
            pend_keep_reg <= s_tkeep;
            pend_last_reg <= s_tlast;
        end
    end

    // -----------------------------------------------------------------------
    // Statistics counters
    // -----------------------------------------------------------------------
    logic [31:0] beat_cnt_reg, pkt_cnt_reg, stall_cnt_reg;
    logic [63:0] byte_cnt_reg;
    logic        proto_err_reg;
    logic [2:0]  err_code_reg;

    function automatic logic [31:0] inc32(input logic [31:0] v);
        if (CNT_SAT != 0 && v == 32'hFFFF_FFFF)
            return v;
        return v + 32'd1;
    endfunction

    function automatic logic [63:0] add_bytes(input logic [63:0] v, input logic [PCW-1:0] n);
        logic [64:0] sum;
        sum = {1'b0, v} + {{(65-PCW){1'b0}}, n};
        if (CNT_SAT != 0 && sum[64])
            return 64'hFFFF_FFFF_FFFF_FFFF;
        return sum[63:0];
    endfunction

    always_ff @(posedge traffic_clk or negedge rstn) begin
        if (!rstn) begin
            pend_reg      <= 1'b0;
            beat_cnt_reg  <= 32'd0;
            byte_cnt_reg  <= 64'd0;
            pkt_cnt_reg   <= 32'd0;
            stall_cnt_reg <= 32'd0;
            proto_err_reg <= 1'b0;
            err_code_reg  <= 3'd0;
        end else begin
            pend_reg <= stall;
            if (clear) begin
                beat_cnt_reg  <= 32'd0;
                byte_cnt_reg  <= 64'd0;
                pkt_cnt_reg   <= 32'd0;
                stall_cnt_reg <= 32'd0;
                proto_err_reg <= 1'b0;
                err_code_reg  <= 3'd0;
            end else begin
                if (accept) begin
                    beat_cnt_reg <= inc32(beat_cnt_reg);
                    byte_cnt_reg <= add_bytes(byte_cnt_reg, keep_pc);
                    if (s_tlast)
                        pkt_cnt_reg <= inc32(pkt_cnt_reg);
                end
                if (stall)
                    stall_cnt_reg <= inc32(stall_cnt_reg);
                if (err_cur != 3'd0) begin
                    proto_err_reg <= 1'b1;
                    // first error sticks
                    if (err_code_reg == 3'd0)
                        err_code_reg <= err_cur;
                end
            end
        end
    end

    assign beat_cnt  = beat_cnt_reg;
    assign byte_cnt  = byte_cnt_reg;
    assign pkt_cnt   = pkt_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
    assign proto_err = proto_err_reg;
    assign err_code  = err_code_reg;

    // -----------------------------------------------------------------------
    // Packet length statistics
    // -----------------------------------------------------------------------
`ifdef SINK_PKT_LEN_STATS_EN
    logic [31:0] acc_reg;
    logic [31:0] min_len_reg, max_len_reg;
    logic        first_pkt_reg;
    logic [31:0] pkt_len;

    assign pkt_len = acc_reg + 32'(keep_pc);

    always_ff @(posedge traffic_clk or negedge rstn) begin
        if (!rstn) begin
            acc_reg       <= 32'd0;
            min_len_reg   <= 32'd0;
            max_len_reg   <= 32'd0;
            first_pkt_reg <= 1'b1;
        end else if (clear) begin
            // an in-flight packet restarts its length from the next beat
            acc_reg       <= 32'd0;
            min_len_reg   <= 32'd0;
            max_len_reg   <= 32'd0;
            first_pkt_reg <= 1'b1;
        end else if (accept) begin
            if (s_tlast) begin
                acc_reg       <= 32'd0;
                first_pkt_reg <= 1'b0;
                if (pkt_len > max_len_reg)
                    max_len_reg <= pkt_len;
                if (first_pkt_reg || pkt_len < min_len_reg)
                    min_len_reg <= pkt_len;
            end else begin
                acc_reg <= pkt_len;
            end
        end
    end

    assign min_pkt_len = min_len_reg;
    assign max_pkt_len = max_len_reg;
`else
    assign min_pkt_len = 32'd0;
    assign max_pkt_len = 32'd0;
`endif

endmodule

// File: tb/tb_axis_app_sink_checker.sv
module tb_axis_app_sink_checker;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic          traffic_clk;
    logic          rstn;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [1:0]    ready_mode;
    logic [7:0]    ready_duty;
    logic [15:0]   lfsr_seed;
    logic          clear;
    logic [31:0]   beat_cnt;
    logic [63:0]   byte_cnt;
    logic [31:0]   pkt_cnt;
    logic [31:0]   stall_cnt;
    logic          proto_err;
    logic [2:0]    err_code;
    logic [31:0]   min_pkt_len;
    logic [31:0]   max_pkt_len;

    int n_checks = 0;
    int n_errors = 0;

    axis_app_sink_checker #(.DWIDTH(DW), .CNT_SAT(1)) dut (
        .traffic_clk (traffic_clk),
        .rstn        (rstn),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .ready_mode  (ready_mode),
        .ready_duty  (ready_duty),
        .lfsr_seed   (lfsr_seed),
        .clear       (clear),
        .beat_cnt    (beat_cnt),
        .byte_cnt    (byte_cnt),
        .pkt_cnt     (pkt_cnt),
        .stall_cnt   (stall_cnt),
        .proto_err   (proto_err),
        .err_code    (err_code),
        .min_pkt_len (min_pkt_len),
        .max_pkt_len (max_pkt_len)
    );

    initial traffic_clk = 1'b0;
    always #5 traffic_clk = ~traffic_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a beat and hold it until it is accepted (bounded wait).
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        logic got;
        got = 1'b0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            got = s_tready;   // stable until the coming posedge
            @(negedge traffic_clk);
        end
        check("send_accept", {63'd0, got}, 64'd1);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(negedge traffic_clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge traffic_clk);
        clear = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [KW-1:0] keep_full;
    logic [KW-1:0] keep_40;
    logic [DW-1:0] dat;
    logic [15:0]   m;
    int            ready_hi;

    initial begin
        keep_full  = '1;
        keep_40    = 64'h0000_00FF_FFFF_FFFF;
        dat        = '0;
        rstn       = 1'b0;
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tlast    = 1'b0;
        s_tvalid   = 1'b0;
        ready_mode = 2'd0;
        ready_duty = 8'd0;
        lfsr_seed  = 16'd0;
        clear      = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge traffic_clk);
        check("rst_tready", {63'd0, s_tready}, 64'd0);
        check("rst_beat",   {32'd0, beat_cnt}, 64'd0);
        check("rst_byte",   byte_cnt, 64'd0);
        check("rst_err",    {61'd0, err_code}, 64'd0);
        rstn = 1'b1;

        // ---------------- mode 0: 10 packets of 3 beats ----------------
        idle(1);
        for (int p = 0; p < 10; p++) begin
            for (int b = 0; b < 3; b++) begin
                dat = {64{p[3:0], b[3:0]}};
                send(dat, (b == 2) ? keep_40 : keep_full, b == 2);
            end
        end
        idle(1);
        $display("mode0: beats=%0d bytes=%0d pkts=%0d stalls=%0d", beat_cnt, byte_cnt, pkt_cnt, stall_cnt);
        check("m0_beat",  {32'd0, beat_cnt}, 64'd30);
        check("m0_byte",  byte_cnt, 64'd1680);
        check("m0_pkt",   {32'd0, pkt_cnt}, 64'd10);
        check("m0_stall", {32'd0, stall_cnt}, 64'd0);
        check("m0_perr",  {63'd0, proto_err}, 64'd0);
`ifdef SINK_PKT_LEN_STATS_EN
        check("m0_min", {32'd0, min_pkt_len}, 64'd168);
        check("m0_max", {32'd0, max_pkt_len}, 64'd168);
`else
        check("m0_min", {32'd0, min_pkt_len}, 64'd0);
        check("m0_max", {32'd0, max_pkt_len}, 64'd0);
`endif

        // ---------------- mode 1: periodic, duty 128 ----------------
        ready_mode = 2'd1;
        ready_duty = 8'd128;
        do_clear();
        idle(1);
        ready_hi  = 0;
        dat       = {16{32'hC0DE_0001}};
        s_tdata   = dat;
        s_tkeep   = keep_full;
        s_tlast   = 1'b0;
        s_tvalid  = 1'b1;
        for (int c = 0; c < 512; c++) begin
            if (s_tready) ready_hi++;
            @(negedge traffic_clk);
        end
        $display("mode1: ready_hi=%0d stalls=%0d beats=%0d", ready_hi, stall_cnt, beat_cnt);
        check("m1_ready_hi", 64'(ready_hi), 64'd256);
        check("m1_stall",    {32'd0, stall_cnt}, 64'd256);
        check("m1_beat",     {32'd0, beat_cnt}, 64'd256);
        send(dat, keep_full, 1'b0);   // let the stalled beat complete
        idle(1);
        check("m1_perr", {63'd0, proto_err}, 64'd0);

        // ---------------- mode 2: LFSR, seed 0 -> ACE1 ----------------
        ready_mode = 2'd2;
        ready_duty = 8'd128;
        lfsr_seed  = 16'd0;
        for (int pass = 0; pass < 2; pass++) begin
            do_clear();
            m = 16'hACE1;
            for (int c = 0; c < 16; c++) begin
                @(negedge traffic_clk);
                check($sformatf("m2_p%0d_c%0d", pass, c), {63'd0, s_tready},
                      {63'd0, (m[7:0] < 8'd128)});
                m = lfsr_adv(m);
            end
            $display("mode2: pass %0d sequence compared, lfsr model now %h", pass, m);
        end

        // ---------------- mode 3: valid dropped while pending ----------------
        ready_mode = 2'd3;
        do_clear();
        s_tdata  = dat;
        s_tkeep  = keep_full;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        repeat (2) @(negedge traffic_clk);
        s_tvalid = 1'b0;
        @(negedge traffic_clk);
        $display("mode3: proto_err=%0d err_code=%0d stalls=%0d", proto_err, err_code, stall_cnt);
        check("m3_perr",  {63'd0, proto_err}, 64'd1);
        check("m3_code",  {61'd0, err_code}, 64'd1);
        check("m3_stall", {32'd0, stall_cnt}, 64'd2);
        ready_mode = 2'd0;
        idle(2);
        send(dat, 64'h1, 1'b0);
        idle(1);
        check("m3_code_kept", {61'd0, err_code}, 64'd1);
        check("m3_beat",      {32'd0, beat_cnt}, 64'd1);

        // ---------------- tkeep legality ----------------
        do_clear();
        check("clr_perr", {63'd0, proto_err}, 64'd0);
        check("clr_code", {61'd0, err_code}, 64'd0);
        send(dat, {1'b0, {63{1'b1}}}, 1'b0);
        idle(1);
        $display("keep: non-last hole -> err_code=%0d", err_code);
        check("e3_code", {61'd0, err_code}, 64'd3);
        do_clear();
        send(dat, 64'h5, 1'b1);
        idle(1);
        $display("keep: last 0x5 -> err_code=%0d", err_code);
        check("e4_code", {61'd0, err_code}, 64'd4);
        check("e4_perr", {63'd0, proto_err}, 64'd1);

        // ---------------- saturation and async reset ----------------
        do_clear();
        force dut.beat_cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.beat_cnt_reg;
        send(dat, keep_full, 1'b0);
        check("sat_1", {32'd0, beat_cnt}, 64'hFFFF_FFFF);
        send(dat, keep_full, 1'b0);
        send(dat, keep_full, 1'b0);
        $display("sat: beat_cnt=%h byte_cnt=%0d", beat_cnt, byte_cnt);
        check("sat_3",    {32'd0, beat_cnt}, 64'hFFFF_FFFF);
        check("sat_byte", byte_cnt, 64'd192);
        // mid-packet, valid still high: reset without a clock edge
        #1 rstn = 1'b0;
        #1;
        $display("async reset: tready=%0d beats=%0d bytes=%0d", s_tready, beat_cnt, byte_cnt);
        check("ar_tready", {63'd0, s_tready}, 64'd0);
        check("ar_beat",   {32'd0, beat_cnt}, 64'd0);
        check("ar_byte",   byte_cnt, 64'd0);
        check("ar_pkt",    {32'd0, pkt_cnt}, 64'd0);
        check("ar_stall",  {32'd0, stall_cnt}, 64'd0);
        check("ar_perr",   {63'd0, proto_err}, 64'd0);
        check("ar_code",   {61'd0, err_code}, 64'd0);
        check("ar_min",    {32'd0, min_pkt_len}, 64'd0);
        check("ar_max",    {32'd0, max_pkt_len}, 64'd0);
        s_tvalid = 1'b0;
        @(negedge traffic_clk);
        rstn = 1'b1;
        @(negedge traffic_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_app_sink_checker.md
Name: axis_app_sink_checker

Overview:
- Downstream consumer of the generator's app-side TX stream (to_app_*), used as the application stand-in for bring-up and throughput characterisation.
- Drives a programmable tready pattern as backpressure.
- Checks AXI-Stream protocol and tkeep legality, and accumulates beat, byte, packet and stall statistics for the stats/debug bus.
- Sits in the traffic_clk domain.

Parameters:
- DWIDTH, 512, tdata width in bits; multiple of 8, 64..512; tkeep width = DWIDTH/8.
- CNT_SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap.

Ports:
- traffic_clk  in  1  stream and logic clock
- rstn  in  1  asynchronous active-low reset
- s_tdata  in  DWIDTH  stream data
- s_tkeep  in  DWIDTH/8  byte enables, bit i qualifies byte i (LSB-first)
- s_tlast  in  1  end of packet
- s_tvalid  in  1  beat valid
- s_tready  out  1  beat accept, driven directly from a flop
- ready_mode  in  2  0 = always, 1 = periodic, 2 = LFSR random, 3 = never
- ready_duty  in  8  ready threshold for modes 1 and 2
- lfsr_seed  in  16  LFSR seed; 0 maps to 16'hACE1
- clear  in  1  synchronous clear of counters, errors and LFSR
- beat_cnt  out  32  accepted beats
- byte_cnt  out  64  sum of popcount(s_tkeep) over accepted beats
- pkt_cnt  out  32  accepted beats with s_tlast = 1
- stall_cnt  out  32  cycles with s_tvalid = 1 and s_tready = 0
- proto_err  out  1  sticky: any error seen
- err_code  out  3  code of the first error; later errors do not overwrite it
- min_pkt_len  out  32  optional-feature statistic
- max_pkt_len  out  32  optional-feature statistic

Behaviour:
- Reset (rstn low, asynchronous):
  - all counters, proto_err, err_code, min_pkt_len and max_pkt_len = 0;
  - s_tready = 0;
  - LFSR = mapped lfsr_seed;
  - phase counter = 0.
- Handshake: a beat is accepted on a clock edge where s_tvalid & s_tready = 1.
- Ready generation: s_tready for cycle n+1 is registered from the cycle-n decision; one-cycle latency from a ready_mode change.
  - Mode 0: ready = 1.
  - Mode 1: 8-bit phase counter increments every cycle and wraps 255 -> 0; ready = (phase < ready_duty). ready_duty = 0 gives never-ready; 255 gives 255 ready cycles per 256.
  - Mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle; ready = (lfsr[7:0] < ready_duty).
  - Mode 3: ready = 0.
- Stall tracking:
  - A beat is pending while s_tvalid = 1 and s_tready = 0.
  - Pending tdata, tkeep and tlast are latched.
- Error checks, in priority order (lowest code wins if several fire in one cycle):
  - 1: s_tvalid deasserted while a beat is pending.
  - 2: tdata, tkeep or tlast changed while a beat is pending.
  - 3: accepted non-last beat with tkeep not all-ones.
  - 4: accepted last beat with tkeep = 0 or not contiguous from bit 0 (must be 2^k-1).
  - err_code = 0 means no error.
- Counters:
  - Update on the accepting edge; visible the next cycle.
  - popcount is combinational over DWIDTH/8 bits.
  - stall_cnt increments in every stall cycle.
  - With CNT_SAT = 1, a counter at all-ones holds.
- clear:
  - Zeroes counters, min_pkt_len, max_pkt_len, proto_err and err_code.
  - Reloads LFSR, zeroes phase and zeroes the in-packet byte accumulator.
  - Takes priority over a same-cycle increment; a beat accepted in the clear cycle is not counted.
  - s_tready is unaffected by clear.
- Packet boundaries: the in-packet byte accumulator resets after each tlast beat; a packet that is in flight during clear restarts its length count from the next beat.

Optional Feature:
- Macro: SINK_PKT_LEN_STATS_EN.
- Defined:
  - On each accepted tlast beat, packet length = accumulator + popcount(tkeep).
  - max_pkt_len = max(previous, length).
  - min_pkt_len = length on the first packet after reset or clear, otherwise min(previous, length).
- Not defined: min_pkt_len and max_pkt_len tied to 0 and the accumulator is not synthesised.

Test Plan:
- Mode 0, DWIDTH = 512, 10 packets of 3 full beats, last beat keep = 64'h0000_00FF_FFFF_FFFF (40 bytes) -> beat_cnt = 30, pkt_cnt = 10, byte_cnt = 1680, stall_cnt = 0, proto_err = 0; with the macro, min = max = 168.
- Mode 1, ready_duty = 128, continuous tvalid for 512 cycles -> s_tready high exactly 256 of 512 cycles; stall_cnt = 256.
- Mode 2, lfsr_seed = 0 -> LFSR starts at 16'hACE1; ready sequence matches the reference LFSR model cycle-for-cycle; clear reproduces the same sequence.
- Mode 3 with s_tvalid dropped after 2 stalled cycles -> proto_err = 1, err_code = 1; a later beat with illegal tkeep leaves err_code = 1.
- Non-last beat with keep = all-ones minus bit 63 -> err_code = 3. Separately, last beat with keep = 64'h5 -> err_code = 4.
- CNT_SAT = 1, beat_cnt forced near 32'hFFFF_FFFE, 3 beats accepted -> beat_cnt holds at 32'hFFFF_FFFF. Assert rstn low mid-packet -> all outputs 0 asynchronously and s_tready = 0.
